data_sram_bridge: RTL and testbench
===================================

# data_sram_bridge

Memory-stage access unit between the pipeline's M stage and the data SRAM-like bus. It turns a load or store in M into a single request/response transaction and stalls the pipeline until the data phase completes. It produces byte strobes and lane-replicated store data, and returns sign- or zero-extended load data ready for the W-stage register. Misaligned addresses are flagged as address errors and no bus request is issued for them.

## Interface
Parameters: none (32-bit MIPS datapath, little-endian lanes).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- valid_m  in  1  M stage holds a real instruction (not a bubble)
- op_m  in  6  M-stage opcode: LW 100011, LB 100000, LBU 100100, LH 100001, LHU 100101, SW 101011, SH 101001, SB 101000; any other value is a non-memory op
- addr_m  in  32  effective address (ALU result in M)
- wdata_m  in  32  raw rt value for stores
- m_advance  in  1  M→W pipeline register enable this cycle
- stall_m  out  1  hold F/D/E/M stages
- rdata_m  out  32  extended load result
- adel  out  1  load address error
- ades  out  1  store address error
- data_sram_req  out  1  request valid
- data_sram_wr  out  1  1 = write
- data_sram_size  out  2  0 = byte, 1 = half, 2 = word
- data_sram_addr  out  32  byte address
- data_sram_wstrb  out  4  byte enables (0000 for reads)
- data_sram_wdata  out  32  write data
- data_sram_addr_ok  in  1  address phase accepted
- data_sram_data_ok  in  1  data phase complete
- data_sram_rdata  in  32  read data, valid with data_ok

## Operation
- mem_op = valid_m and op_m is one of the eight codes above.
- Misalignment: word ops need addr[1:0] = 00; half ops need addr[0] = 0. A misaligned load asserts adel; a misaligned store asserts ades. Both are combinational and asserted only in IDLE. No request is made, stall_m = 0, and rdata_m = 0.
- FSM has four states: IDLE, REQ, WAIT, DONE.
  - IDLE: on mem_op and aligned, latch op, addr, and formatted wdata/wstrb, then go to REQ. Otherwise stay.
  - REQ: data_sram_req = 1. Bus outputs come from latched values only. On addr_ok go to WAIT.
  - WAIT: req = 0. On data_ok, capture data_sram_rdata and go to DONE. data_ok is honoured only in WAIT and ignored in every other state.
  - DONE: hold the result. On m_advance go to IDLE.
- stall_m = (IDLE and mem_op and aligned) or REQ or WAIT. In DONE, stall_m = 0.
- Store formatting:
  - SW: wdata = word, wstrb = 1111.
  - SH: wdata = {2{wdata_m[15:0]}}, wstrb = 0011 for addr[1] = 0, 1100 for addr[1] = 1.
  - SB: wdata = {4{wdata_m[7:0]}}, wstrb = 0001 << addr[1:0].
- Load extraction uses the latched addr[1:0].
  - Byte: lane addr[1:0] (lane 0 = bits 7:0). LB sign-extends; LBU zero-extends.
  - Half: bits 15:0 when addr[1] = 0, 31:16 when addr[1] = 1. LH sign-extends; LHU zero-extends.
  - LW: whole word.
- rdata_m shows the extended value in DONE and is 0 in all other states. Stores give rdata_m = 0.
- data_sram_size: 0 for byte ops, 1 for half ops, 2 for word ops. data_sram_wr = 1 for stores.

## Timing
- Reset forces state to IDLE and clears all latched registers. Every output reads 0: stall_m, rdata_m, adel, ades, req, wr, size, addr, wstrb, wdata.
- Reset mid-transaction (REQ/WAIT/DONE) abandons it and returns to IDLE. A late data_ok is ignored.
- Minimum latency with addr_ok on the first REQ cycle and data_ok on the next cycle:
  - cycle 0: IDLE, stall
  - cycle 1: REQ
  - cycle 2: WAIT
  - cycle 3: DONE, stall_m = 0
  - The total is 3 stall cycles.
- Each cycle of addr_ok or data_ok delay adds one stall cycle.
- data_sram_req stays high, with stable addr/wstrb/wdata/size/wr, until the cycle addr_ok is sampled high.
- In DONE with m_advance = 0, the state, rdata_m, and stall_m = 0 hold indefinitely. No new request is issued until DONE→IDLE.
- One outstanding transaction at most.

## Test plan
- LW to 0x0000_0010, slave gives addr_ok immediately and data_ok one cycle later with rdata 0xDEAD_BEEF → stall_m high for exactly 3 cycles, rdata_m = 0xDEAD_BEEF in DONE, size = 2, wstrb = 0000.
- SB with addr 0x0000_0013 and wdata_m 0x1234_56AB → req with wr = 1, wstrb = 1000, wdata = 0xABAB_ABAB, size = 0. addr_ok is held off 3 cycles → req and outputs stay stable, and stall lasts 6 cycles.
- LH at addr 0x…02 with rdata 0x8001_1234 → rdata_m = 0xFFFF_8001. LHU at addr 0x…00 → 0x0000_1234. LB at addr 0x…01 → 0x0000_0012. LBU at addr 0x…03 with rdata 0xF000_0000 → 0x0000_00F0.
- LW at 0x…02 → adel = 1, no req, stall_m = 0. SH at 0x…01 → ades = 1, no req.
- Hold m_advance = 0 for 4 cycles in DONE → rdata_m stable, req stays 0. Raise m_advance → IDLE next cycle.
- Assert rst during WAIT, then pulse data_ok → state IDLE, all outputs 0, and the late data_ok has no effect.

Source files
------------

// File: rtl/data_sram_bridge.sv
// M-stage load/store unit: one request/response transaction per memory op on the
// data SRAM-like bus, with store lane formatting and load extension.
module data_sram_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_m,
  input  logic [5:0]  op_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  input  logic        m_advance,
  output logic        stall_m,
  output logic [31:0] rdata_m,
  output logic        adel,
  output logic        ades,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        wr_q, wr_d, uns_q, uns_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic        mem_op, misal, start;
  logic [1:0]  size_m;
  logic [31:0] fmt_wdata, ext;
  logic [3:0]  fmt_wstrb;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (op_m)
      6'b100011, 6'b100000, 6'b100100, 6'b100001,
      6'b100101, 6'b101011, 6'b101001, 6'b101000: mem_op = valid_m;
      default:                                   mem_op = 1'b0;
    endcase
  end

  // op_m[1:0] encodes access width: 00 byte, 01 half, 11 word; op_m[3] = store
  assign size_m = op_m[1] ? 2'd2 : {1'b0, op_m[0]};
  assign misal  = ((size_m == 2'd2) && (addr_m[1:0] != 2'b00)) ||
                  ((size_m == 2'd1) && addr_m[0]);
  assign start  = (state_q == IDLE) && mem_op && !misal;

  always_comb begin
    fmt_wdata = wdata_m;
    fmt_wstrb = 4'b1111;
    case (size_m)
      2'd0: begin
        fmt_wdata = {4{wdata_m[7:0]}};
        fmt_wstrb = 4'b0001 << addr_m[1:0];
      end
      2'd1: begin
        fmt_wdata = {2{wdata_m[15:0]}};
        fmt_wstrb = addr_m[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!op_m[3]) begin
      fmt_wdata = '0;
      fmt_wstrb = 4'b0000;
    end
  end

  always_comb begin
    lane_b = 8'(data_sram_rdata >> {addr_q[1:0], 3'b000});
    lane_h = addr_q[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
    case (size_q)
      2'd0:    ext = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'd1:    ext = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: ext = data_sram_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    wr_d    = wr_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = REQ;
        size_d  = size_m;
        wr_d    = op_m[3];
        uns_d   = op_m[2];
        addr_d  = addr_m;
        wdata_d = fmt_wdata;
        wstrb_d = fmt_wstrb;
        rdata_d = '0;
      end
      REQ:  if (data_sram_addr_ok) state_d = WAIT;
      WAIT: if (data_sram_data_ok) begin
        state_d = DONE;
        rdata_d = wr_q ? '0 : ext;
      end
      DONE: if (m_advance) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      size_q  <= '0;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

  assign stall_m         = start || (state_q == REQ) || (state_q == WAIT);
  assign rdata_m         = (state_q == DONE) ? rdata_q : '0;
  assign adel            = (state_q == IDLE) && mem_op && misal && !op_m[3];
  assign ades            = (state_q == IDLE) && mem_op && misal && op_m[3];
  assign data_sram_req   = (state_q == REQ);
  assign data_sram_wr    = wr_q;
  assign data_sram_size  = size_q;
  assign data_sram_addr  = addr_q;
  assign data_sram_wstrb = wstrb_q;
  assign data_sram_wdata = wdata_q;
endmodule

// File: tb/tb_data_sram_bridge.sv
// Randomized self-checking bench for data_sram_bridge against an arithmetic
// reference model of the load/store formatting and transaction timing.
module tb_data_sram_bridge;
  localparam logic [5:0] LW = 6'b100011, LB = 6'b100000, LBU = 6'b100100, LH = 6'b100001;
  localparam logic [5:0] LHU = 6'b100101, SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;

  logic        clk = 1'b0, rst = 1'b1, valid_m = 1'b0, m_advance = 1'b0;
  logic [5:0]  op_m = '0;
  logic [31:0] addr_m = '0, wdata_m = '0;
  logic        stall_m, adel, ades, req, wr;
  logic [31:0] rdata_m, s_addr, s_wdata;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic        addr_ok = 1'b0, data_ok = 1'b0;
  logic [31:0] d_rdata = '0;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  data_sram_bridge dut (
    .clk(clk), .rst(rst), .valid_m(valid_m), .op_m(op_m), .addr_m(addr_m),
    .wdata_m(wdata_m), .m_advance(m_advance), .stall_m(stall_m), .rdata_m(rdata_m),
    .adel(adel), .ades(ades), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(s_size), .data_sram_addr(s_addr), .data_sram_wstrb(s_wstrb),
    .data_sram_wdata(s_wdata), .data_sram_addr_ok(addr_ok),
    .data_sram_data_ok(data_ok), .data_sram_rdata(d_rdata)
  );

  function automatic bit is_store(logic [5:0] op);
    return op == SW || op == SH || op == SB;
  endfunction

  function automatic logic [1:0] ref_size(logic [5:0] op);
    if (op == LB || op == LBU || op == SB) return 2'd0;
    if (op == LH || op == LHU || op == SH) return 2'd1;
    return 2'd2;
  endfunction

  function automatic bit ref_misal(logic [5:0] op, logic [31:0] a);
    if (ref_size(op) == 2'd2) return (a % 4) != 0;
    if (ref_size(op) == 2'd1) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] ref_wstrb(logic [5:0] op, logic [31:0] a);
    case (op)
      SW: return 4'hF;
      SH: return (a % 4 >= 2) ? 4'hC : 4'h3;
      SB: return 4'(1 << (a % 4));
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(logic [5:0] op, logic [31:0] wd);
    case (op)
      SW: return wd;
      SH: return (wd & 32'hFFFF) * 32'h0001_0001;
      SB: return (wd & 32'hFF) * 32'h0101_0101;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(logic [5:0] op, logic [31:0] a, logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> ((a % 4 >= 2) ? 16 : 0)) & 32'hFFFF;
    case (op)
      LW:  return rd;
      LBU: return b;
      LB:  return (b >= 32'h80) ? b - 32'h100 : b;
      LHU: return h;
      LH:  return (h >= 32'h8000) ? h - 32'h1_0000 : h;
      default: return 32'h0;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1; valid_m = 1'b0; m_advance = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives one aligned op through the bus, acting as the slave; reports what it saw.
  task automatic run_txn(input logic [5:0] op, input logic [31:0] a, wd, rd,
                         input int ad, dd, hold, input bit junk,
                         output int stalls, output logic [40:0] bus, output logic [31:0] bwd,
                         output bit stable, output logic [31:0] rres,
                         output bit hold_ok, output bit tmo);
    int reqc, waitc;
    bit seen, done;
    reqc = 0; waitc = 0; seen = 0; done = 0;
    stalls = 0; stable = 1; hold_ok = 1; tmo = 0; rres = '0; bus = '0; bwd = '0;
    @(posedge clk); #1;
    valid_m = 1'b1; op_m = op; addr_m = a; wdata_m = wd; m_advance = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      addr_ok = 1'b0; data_ok = 1'b0; d_rdata = $urandom;
      if (stall_m) stalls++;
      if (req) begin
        if (!seen) begin bus = {wr, s_size, s_addr, s_wstrb}; bwd = s_wdata; end
        else if ({wr, s_size, s_addr, s_wstrb, s_wdata} !== {bus, bwd}) stable = 0;
        seen = 1; reqc++;
        addr_ok = (reqc > ad);
        if (junk) begin data_ok = 1'b1; d_rdata = ~rd; end
      end else if (seen && stall_m) begin
        waitc++;
        if (waitc > dd) begin data_ok = 1'b1; d_rdata = rd; end
      end else if (seen) begin
        done = 1; rres = rdata_m;
      end else if (junk) begin
        data_ok = 1'b1; d_rdata = ~rd;
      end
    end
    if (!done) begin
      tmo = 1;
      do_reset();
      return;
    end
    for (int h = 0; h < hold; h++) begin
      if (junk) begin data_ok = 1'b1; d_rdata = ~rd; end
      @(posedge clk);
      @(negedge clk);
      data_ok = 1'b0;
      if (rdata_m !== rres || req !== 1'b0 || stall_m !== 1'b0) hold_ok = 0;
    end
    m_advance = 1'b1;
    @(posedge clk); #1;
    valid_m = 1'b0; m_advance = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_chk++;
    if ({stall_m, rdata_m, adel, ades, req, wr, s_size, s_addr, s_wstrb, s_wdata} !== '0)
      $display("FAIL reset_outputs: got stall=%b rdata=%h req=%b addr=%h wstrb=%b, want all 0",
               stall_m, rdata_m, req, s_addr, s_wstrb);
    else n_pass++;
  endtask

  task automatic test_lw_min();
    int st; logic [40:0] bus; logic [31:0] bwd, rr; bit stb, hok, tmo;
    run_txn(LW, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0, st, bus, bwd, stb, rr, hok, tmo);
    n_chk++;
    if (tmo || st !== 3) $display("FAIL lw_stall: got %0d cycles (timeout=%0b), want 3", st, tmo);
    else n_pass++;
    n_chk++;
    if (rr !== 32'hDEAD_BEEF) $display("FAIL lw_rdata: got %h, want deadbeef", rr);
    else n_pass++;
    n_chk++;
    if (bus !== {1'b0, 2'd2, 32'h10, 4'b0000})
      $display("FAIL lw_bus: got wr/size/addr/wstrb %h, want %h", bus, {1'b0, 2'd2, 32'h10, 4'b0000});
    else n_pass++;
  endtask

  task automatic test_sb_delay();
    int st; logic [40:0] bus; logic [31:0] bwd, rr; bit stb, hok, tmo;
    run_txn(SB, 32'h13, 32'h1234_56AB, 32'h0, 3, 0, 0, 0, st, bus, bwd, stb, rr, hok, tmo);
    n_chk++;
    if (tmo || st !== 6) $display("FAIL sb_stall: got %0d cycles (timeout=%0b), want 6", st, tmo);
    else n_pass++;
    n_chk++;
    if (bus !== {1'b1, 2'd0, 32'h13, 4'b1000} || bwd !== 32'hABAB_ABAB)
      $display("FAIL sb_bus: got %h wdata %h, want %h wdata abababab",
               bus, bwd, {1'b1, 2'd0, 32'h13, 4'b1000});
    else n_pass++;
    n_chk++;
    if (!stb) $display("FAIL sb_stable: request fields changed while addr_ok was held off");
    else n_pass++;
  endtask

  task automatic test_load_ext();
    logic [5:0]  ops [4] = '{LH, LHU, LB, LBU};
    logic [31:0] as  [4] = '{32'h102, 32'h100, 32'h101, 32'h103};
    logic [31:0] rds [4] = '{32'h8001_1234, 32'h8001_1234, 32'h8001_1234, 32'hF000_0000};
    logic [31:0] exp [4] = '{32'hFFFF_8001, 32'h0000_1234, 32'h0000_0012, 32'h0000_00F0};
    int st; logic [40:0] bus; logic [31:0] bwd, rr; bit stb, hok, tmo;
    for (int i = 0; i < 4; i++) begin
      run_txn(ops[i], as[i], 32'h0, rds[i], 0, 1, 0, 1, st, bus, bwd, stb, rr, hok, tmo);
      n_chk++;
      if (tmo || rr !== exp[i]) $display("FAIL load_ext%0d: got %h, want %h", i, rr, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_misaligned();
    logic [5:0]  ops [2] = '{LW, SH};
    logic [31:0] as  [2] = '{32'h102, 32'h101};
    logic o_adel, o_ades, o_stall, o_req; logic [31:0] o_rd;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      valid_m = 1'b1; op_m = ops[i]; addr_m = as[i]; wdata_m = 32'h5555_AAAA;
      @(negedge clk);
      o_adel = adel; o_ades = ades; o_stall = stall_m; o_rd = rdata_m;
      @(negedge clk);
      o_req = req;
      valid_m = 1'b0;
      n_chk++;
      if ({o_adel, o_ades, o_stall, o_req, o_rd} !== {i == 0, i == 1, 1'b0, 1'b0, 32'h0})
        $display("FAIL misalign%0d: got adel=%b ades=%b stall=%b req=%b rdata=%h", i,
                 o_adel, o_ades, o_stall, o_req, o_rd);
      else n_pass++;
    end
  endtask

  task automatic test_done_hold();
    int st; logic [40:0] bus; logic [31:0] bwd, rr; bit stb, hok, tmo;
    run_txn(LW, 32'h200, 32'h0, 32'h1357_9BDF, 1, 2, 4, 1, st, bus, bwd, stb, rr, hok, tmo);
    n_chk++;
    if (tmo || !hok || rr !== 32'h1357_9BDF)
      $display("FAIL done_hold: got rdata %h hold_ok=%0b timeout=%0b, want 13579bdf held", rr, hok, tmo);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({rdata_m, stall_m, req} !== '0)
      $display("FAIL done_advance: got rdata=%h stall=%b req=%b, want idle zeros", rdata_m, stall_m, req);
    else n_pass++;
  endtask

  task automatic test_reset_wait();
    int st; logic [40:0] bus; logic [31:0] bwd, rr; bit stb, hok, tmo;
    @(posedge clk); #1;
    valid_m = 1'b1; op_m = LW; addr_m = 32'h40;
    @(negedge clk);
    @(negedge clk);
    addr_ok = 1'b1;
    @(posedge clk); #1;
    addr_ok = 1'b0; valid_m = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; data_ok = 1'b1; d_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    data_ok = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_chk++;
      if ({stall_m, rdata_m, adel, ades, req, wr, s_size, s_addr, s_wstrb, s_wdata} !== '0)
        $display("FAIL reset_wait%0d: got stall=%b rdata=%h req=%b addr=%h, want all 0",
                 k, stall_m, rdata_m, req, s_addr);
      else n_pass++;
    end
    run_txn(LW, 32'h44, 32'h0, 32'h0BAD_F00D, 0, 0, 0, 0, st, bus, bwd, stb, rr, hok, tmo);
    n_chk++;
    if (tmo || rr !== 32'h0BAD_F00D || st !== 3)
      $display("FAIL post_reset_lw: got rdata %h stall %0d, want 0badf00d 3", rr, st);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [5:0] tbl [9] = '{LW, LB, LBU, LH, LHU, SW, SH, SB, 6'b001000};
    logic [5:0] op; logic [31:0] a, wd, rd, rr, bwd; logic [40:0] bus;
    int ad, dd, st; bit junk, stb, hok, tmo;
    for (int n = 0; n < 40; n++) begin
      op = tbl[$urandom_range(0, 8)]; a = $urandom; wd = $urandom; rd = $urandom;
      ad = $urandom_range(0, 3); dd = $urandom_range(0, 3); junk = 1'($urandom);
      if (op == 6'b001000 || ref_misal(op, a)) begin
        @(posedge clk); #1;
        valid_m = 1'b1; op_m = op; addr_m = a; wdata_m = wd;
        @(negedge clk);
        n_chk++;
        if ({adel, ades, stall_m, req, rdata_m} !==
            {op != 6'b001000 && !is_store(op), op != 6'b001000 && is_store(op), 1'b0, 1'b0, 32'h0})
          $display("FAIL rand_noreq%0d: op=%b addr=%h adel=%b ades=%b stall=%b req=%b",
                   n, op, a, adel, ades, stall_m, req);
        else n_pass++;
        valid_m = 1'b0;
      end else begin
        run_txn(op, a, wd, rd, ad, dd, 0, junk, st, bus, bwd, stb, rr, hok, tmo);
        n_chk++;
        if (tmo || st !== 3 + ad + dd || !stb ||
            bus !== {is_store(op), ref_size(op), a, ref_wstrb(op, a)} ||
            (is_store(op) && bwd !== ref_wdata(op, wd)) ||
            rr !== (is_store(op) ? 32'h0 : ref_load(op, a, rd)))
          $display("FAIL rand_txn%0d: op=%b addr=%h stall=%0d/%0d bus=%h wdata=%h/%h rdata=%h/%h",
                   n, op, a, st, 3 + ad + dd, bus, bwd, ref_wdata(op, wd), rr,
                   is_store(op) ? 32'h0 : ref_load(op, a, rd));
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw_min();
    test_sb_delay();
    test_load_ext();
    test_misaligned();
    test_done_hold();
    test_reset_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
